// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: command codes, frame geometry and FSM states.
package spi_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TURN  = 3'd3,
        ST_RECV  = 3'd4,
        ST_GAP   = 3'd5
    } state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load shift register: shifts towards the MSB, new bit enters at the LSB.
// The MSB of data_o is the serial output.
module spi_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic             shift_in_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            data_d = {data_q[WIDTH-2:0], shift_in_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/spi_master.sv
// SPI master sharing the system clock with the slave: one bit per clk cycle,
// 10-bit {cmd,wdata} frame on MOSI, optional 8-bit read response from MISO.
module spi_master
    import spi_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int IDLE_GAP     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    input  logic [7:0] wdata,
    output logic       cmd_ready,
    output logic       busy,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'((IDLE_GAP > 1) ? IDLE_GAP - 2 : 0);
    localparam logic [3:0]       TURN_LOAD = 4'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
    // The first IDLE cycle already keeps SS_n high, so GAP only covers the
    // remaining IDLE_GAP-1 cycles and is skipped entirely when IDLE_GAP==1.
    localparam state_e END_STATE = (IDLE_GAP > 1) ? ST_GAP : ST_IDLE;

    state_e                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [3:0]            turn_cnt_q, turn_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic                  is_read_q, is_read_d;
    logic                  ss_n_q, ss_n_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, busy_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [7:0]            rd_data_q, rd_data_d;

    logic                  tx_load, tx_shift, rx_shift;
    logic [FRAME_BITS-1:0] tx_data;
    logic [DATA_BITS-1:0]  rx_data;

    spi_shift_reg #(.WIDTH(FRAME_BITS)) u_tx_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (tx_load),
        .load_data_i ({cmd, wdata}),
        .shift_i     (tx_shift),
        .shift_in_i  (1'b0),
        .data_o      (tx_data)
    );

    spi_shift_reg #(.WIDTH(DATA_BITS)) u_rx_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_i     (rx_shift),
        .shift_in_i  (MISO),
        .data_o      (rx_data)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        turn_cnt_d = turn_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        is_read_d  = is_read_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mosi_d     = 1'b0;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        rx_shift   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d   = ST_START;
                    tx_load   = 1'b1;
                    is_read_d = (cmd == CMD_RD_DATA);
                end
            end
            ST_START: begin
                state_d   = ST_SHIFT;
                bit_cnt_d = 4'(FRAME_BITS - 1);
                tx_shift  = 1'b1;
                mosi_d    = tx_data[FRAME_BITS-1];
            end
            ST_SHIFT: begin
                // MOSI is registered, so each cycle presents the bit for the next one.
                if (bit_cnt_q != 4'd0) begin
                    bit_cnt_d = bit_cnt_q - 4'd1;
                    tx_shift  = 1'b1;
                    mosi_d    = tx_data[FRAME_BITS-1];
                end else if (is_read_q) begin
                    if (READ_LATENCY == 0) begin
                        state_d   = ST_RECV;
                        bit_cnt_d = 4'(DATA_BITS - 1);
                    end else begin
                        state_d    = ST_TURN;
                        turn_cnt_d = TURN_LOAD;
                    end
                end else begin
                    state_d   = END_STATE;
                    gap_cnt_d = GAP_LOAD;
                end
            end
            ST_TURN: begin
                if (turn_cnt_q != 4'd0) begin
                    turn_cnt_d = turn_cnt_q - 4'd1;
                end else begin
                    state_d   = ST_RECV;
                    bit_cnt_d = 4'(DATA_BITS - 1);
                end
            end
            ST_RECV: begin
                rx_shift = 1'b1;
                if (bit_cnt_q != 4'd0) begin
                    bit_cnt_d = bit_cnt_q - 4'd1;
                end else begin
                    state_d    = END_STATE;
                    gap_cnt_d  = GAP_LOAD;
                    rd_valid_d = 1'b1;
                    rd_data_d  = {rx_data[DATA_BITS-2:0], MISO};
                end
            end
            ST_GAP: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ss_n_d = !((state_d == ST_START) || (state_d == ST_SHIFT) ||
                   (state_d == ST_TURN)  || (state_d == ST_RECV));
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            turn_cnt_q <= 4'd0;
            gap_cnt_q  <= '0;
            is_read_q  <= 1'b0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            is_read_q  <= is_read_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = busy_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: two instances (READ_LATENCY 2 and 0) share one
// request stream; a per-instance monitor checks each SS_n frame against the queue.
module tb_spi_master;

    typedef struct packed {
        logic [1:0] cmd;
        logic [7:0] wdata;
        logic [7:0] rbyte;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic [7:0]  wdata;
    logic [1:0]  cmd_ready_w, busy_w, rd_valid_w, ss_n_w, mosi_w, miso_w;
    logic [15:0] rd_data_w;

    txn_t        exp_q[$];
    int          rd_ptr[2];
    int          last_gap[2];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    spi_master #(.READ_LATENCY(2), .IDLE_GAP(1)) u_dut_rl2 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .wdata(wdata),
        .cmd_ready(cmd_ready_w[0]), .busy(busy_w[0]), .rd_data(rd_data_w[7:0]),
        .rd_valid(rd_valid_w[0]), .SS_n(ss_n_w[0]), .MOSI(mosi_w[0]), .MISO(miso_w[0])
    );

    spi_master #(.READ_LATENCY(0), .IDLE_GAP(1)) u_dut_rl0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .wdata(wdata),
        .cmd_ready(cmd_ready_w[1]), .busy(busy_w[1]), .rd_data(rd_data_w[15:8]),
        .rd_valid(rd_valid_w[1]), .SS_n(ss_n_w[1]), .MOSI(mosi_w[1]), .MISO(miso_w[1])
    );

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
        end
    endtask

    // One monitor plus slave model per instance.
    for (genvar gi = 0; gi < 2; gi++) begin : g_mon
        initial begin : mon
            int         rl;
            int         high_run;
            int         last_k;
            logic [7:0] last_rd;
            logic [9:0] fr;
            txn_t       t;
            rl       = (gi == 0) ? 2 : 0;
            high_run = 0;
            last_rd  = 8'h00;
            miso_w[gi] = 1'b0;
            forever begin
                @(negedge clk);
                miso_w[gi] = 1'($urandom_range(0, 1));
                if (!rst_n) begin
                    high_run = 0;
                    last_rd  = 8'h00;
                end else if (ss_n_w[gi]) begin
                    high_run++;
                    check("rd_valid_idle", gi, 32'(rd_valid_w[gi]), 0);
                    check("busy_idle", gi, 32'(busy_w[gi]), 0);
                end else if (rd_ptr[gi] >= exp_q.size()) begin
                    check("unexpected_frame", gi, rd_ptr[gi], exp_q.size());
                    for (int w = 0; w < 40 && !ss_n_w[gi]; w++) @(negedge clk);
                end else begin
                    last_gap[gi] = high_run;
                    t  = exp_q[rd_ptr[gi]];
                    rd_ptr[gi]++;
                    fr = {t.cmd, t.wdata};
                    last_k = (t.cmd == 2'b11) ? 19 + rl : 11;
                    for (int k = 0; k <= last_k; k++) begin
                        if (k > 0) begin
                            @(negedge clk);
                            miso_w[gi] = 1'($urandom_range(0, 1));
                        end
                        if (!rst_n) begin
                            last_rd = 8'h00;
                            break;
                        end
                        if (k <= 10) begin
                            check("ss_low", gi, 32'(ss_n_w[gi]), 0);
                            check("mosi_bit", gi, 32'(mosi_w[gi]), (k == 0) ? 0 : 32'(fr[10-k]));
                            check("busy_frame", gi, 32'(busy_w[gi]), 1);
                            check("rd_valid_frame", gi, 32'(rd_valid_w[gi]), 0);
                        end else if (k < last_k) begin
                            if (k >= 11 + rl) miso_w[gi] = t.rbyte[7 - (k - 11 - rl)];
                            check("ss_low_rd", gi, 32'(ss_n_w[gi]), 0);
                            check("mosi_zero", gi, 32'(mosi_w[gi]), 0);
                            check("rd_valid_frame", gi, 32'(rd_valid_w[gi]), 0);
                        end else if (t.cmd == 2'b11) begin
                            check("ss_end_rd", gi, 32'(ss_n_w[gi]), 1);
                            check("rd_valid_pulse", gi, 32'(rd_valid_w[gi]), 1);
                            check("rd_data", gi, 32'(rd_data_w[gi*8 +: 8]), 32'(t.rbyte));
                            last_rd = t.rbyte;
                        end else begin
                            check("ss_end_wr", gi, 32'(ss_n_w[gi]), 1);
                            check("rd_valid_wr", gi, 32'(rd_valid_w[gi]), 0);
                            check("rd_data_hold", gi, 32'(rd_data_w[gi*8 +: 8]), 32'(last_rd));
                        end
                    end
                    high_run = 1;
                end
            end
        end
    end

    task automatic send(input logic [1:0] c, input logic [7:0] w, input logic [7:0] rb);
        txn_t t;
        int   n;
        n = 0;
        @(negedge clk);
        while (cmd_ready_w != 2'b11) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                check("ready_timeout", 0, 32'(cmd_ready_w), 32'h3);
                return;
            end
        end
        t.cmd = c; t.wdata = w; t.rbyte = rb;
        exp_q.push_back(t);
        $display("txn %0d: cmd=%0d wdata=%02h miso_byte=%02h", exp_q.size() - 1, c, w, rb);
        cmd_valid = 1'b1;
        cmd       = c;
        wdata     = w;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd       = 2'($urandom);
        wdata     = 8'($urandom);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd       = 2'b00;
        wdata     = 8'h00;
        rd_ptr[0] = 0; rd_ptr[1] = 0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ss_n", d, 32'(ss_n_w[d]), 1);
            check("rst_mosi", d, 32'(mosi_w[d]), 0);
            check("rst_rd_data", d, 32'(rd_data_w[d*8 +: 8]), 0);
            check("rst_rd_valid", d, 32'(rd_valid_w[d]), 0);
            check("rst_busy", d, 32'(busy_w[d]), 0);
            check("rst_cmd_ready", d, 32'(cmd_ready_w[d]), 1);
        end
        rst_n = 1'b1;

        send(2'b00, 8'h2A, 8'h00);
        send(2'b01, 8'hC3, 8'h00);
        send(2'b10, 8'h2A, 8'h00);
        @(negedge clk); #1;
        for (int d = 0; d < 2; d++) check("gap_cycles", d, last_gap[d], 1);
        send(2'b11, 8'h00, 8'hA5);
        send(2'b11, 8'h00, 8'h3C);

        // Request while a frame is in flight must be dropped.
        send(2'b01, 8'h5A, 8'h00);
        repeat (5) @(negedge clk);
        check("busy_ready", 0, 32'(cmd_ready_w), 0);
        cmd_valid = 1'b1; cmd = 2'b01; wdata = 8'hFF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;

        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        end

        // Reset in the middle of a read-data frame.
        send(2'b11, 8'h00, 8'h96);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("midrst_ss_n", d, 32'(ss_n_w[d]), 1);
            check("midrst_mosi", d, 32'(mosi_w[d]), 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("midrst_ready", d, 32'(cmd_ready_w[d]), 1);
            check("midrst_rd_data", d, 32'(rd_data_w[d*8 +: 8]), 0);
        end
        repeat (30) @(negedge clk);

        send(2'b11, 8'h00, 8'h5C);
        repeat (30) @(negedge clk);
        for (int d = 0; d < 2; d++) check("frames_seen", d, rd_ptr[d], exp_q.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
